// File: rtl/pipelined_ram.sv
// Single-port word RAM with byte enables and a fixed-latency read pipeline.
// Define PIPELINED_RAM_INIT_CLEAR_EN to zero every word after reset before accepting requests.
module pipelined_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int ADDR_W     = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF    = $clog2(BE_W);
  localparam int IDX_HI = DEPTH_LOG2 + OFF;
  localparam int WORDS  = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  acc;
  logic                  clr_we;
  logic [DEPTH_LOG2-1:0] clr_cnt;

  logic                  vld_p  [READ_LAT];
  logic                  err_p  [READ_LAT];
  logic [DATA_W-1:0]     data_p [READ_LAT];

  assign idx = req_addr[IDX_HI-1:OFF];

  generate
    if (ADDR_W > IDX_HI) begin : g_oor
      assign oor = |req_addr[ADDR_W-1:IDX_HI];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
    // Sub-word address bits are deliberately ignored: misaligned accesses align down.
    if (OFF > 0) begin : g_off
      logic unused_low_addr;
      assign unused_low_addr = ^req_addr[OFF-1:0];
    end
  endgenerate

  // A request landing on a reset edge is dropped so reset never disturbs memory.
  assign acc = req_valid && req_ready && rst_n;

`ifdef PIPELINED_RAM_INIT_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {DEPTH_LOG2{1'b1}}) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        default: req_ready <= 1'b1;
      endcase
    end
  end

  assign clr_we = rst_n && (state == CLEAR);
`else
  always_ff @(posedge clk) begin
    if (!rst_n) req_ready <= 1'b0;
    else        req_ready <= 1'b1;
  end

  assign clr_we  = 1'b0;
  assign clr_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (acc && req_write && !oor) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Stage 0: read sampled at the accept edge; later stages only delay it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= acc && !req_write;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !req_write) begin
      data_p[0] <= mem[idx];
      err_p[0]  <= oor;
    end
    for (int i = 1; i < READ_LAT; i++) begin
      data_p[i] <= data_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  // Output stage: data and error are masked by valid, so they need no reset.
  assign resp_valid = vld_p[READ_LAT-1];
  assign resp_err   = vld_p[READ_LAT-1] && err_p[READ_LAT-1];
  assign resp_data  = (vld_p[READ_LAT-1] && !err_p[READ_LAT-1]) ? data_p[READ_LAT-1] : '0;

endmodule

// File: tb/tb_pipelined_ram.sv
// Directed bench for pipelined_ram (DATA_W=32, DEPTH_LOG2=10, READ_LAT=2).
// Also covers the zero-fill sequence when PIPELINED_RAM_INIT_CLEAR_EN is defined.
module tb_pipelined_ram;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int ADDR_W     = 32;
  localparam int READ_LAT   = 2;
`ifdef PIPELINED_RAM_INIT_CLEAR_EN
  localparam int READY_WAIT = 1024;
`else
  localparam int READY_WAIT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  int total = 0;
  int bad   = 0;

  pipelined_ram #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = 4'h0;
  endtask

  // Issues one read and captures the response; ok is set only if valid shows
  // up exactly READ_LAT cycles after acceptance, for one cycle.
  task automatic read_word(input logic [31:0] a, output logic [31:0] data,
                           output logic err, output logic ok);
    logic early, mid, late;
    drive(1'b0, a, 32'h0, 4'h0);
    early = resp_valid;
    step();
    mid  = resp_valid;
    data = resp_data;
    err  = resp_err;
    step();
    late = resp_valid || (resp_data !== 32'h0);
    ok   = !early && mid && !late;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (req_ready !== 1'b1 && cycles < 3000) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", resp_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
    rst_n = 1'b1;
    wait_ready(cyc);
    total++; if (cyc != READY_WAIT) begin bad++; $display("FAIL ready_delay: got %0d want %0d", cyc, READY_WAIT); end
  endtask

`ifdef PIPELINED_RAM_INIT_CLEAR_EN
  task automatic test_init_clear();
    logic [31:0] d; logic e, ok;
    read_word(32'h0, d, e, ok);
    total++; if (!ok || d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL clr_word0: got ok=%b d=%h e=%b want ok=1 d=0 e=0", ok, d, e); end
    read_word(32'hFFC, d, e, ok);
    total++; if (!ok || d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL clr_word_last: got ok=%b d=%h e=%b want ok=1 d=0 e=0", ok, d, e); end
  endtask
`endif

  task automatic test_write_read();
    logic [31:0] d; logic e, ok;
    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    read_word(32'h10, d, e, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_rd_latency: got ok=%b want 1", ok); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data: got %h want deadbeef", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_rd_err: got %b want 0", e); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e, ok;
    drive(1'b1, 32'h20, 32'h11223344, 4'hF);
    drive(1'b1, 32'h22, 32'hAABBCCDD, 4'h4);
    read_word(32'h20, d, e, ok);
    total++; if (!ok || d !== 32'h11BB3344 || e !== 1'b0) begin bad++; $display("FAIL be_lane2: got ok=%b d=%h e=%b want ok=1 d=11bb3344 e=0", ok, d, e); end
    drive(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    read_word(32'h20, d, e, ok);
    total++; if (!ok || d !== 32'h11BB3344) begin bad++; $display("FAIL be_zero: got ok=%b d=%h want ok=1 d=11bb3344", ok, d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e, ok;
    drive(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    read_word(32'h1000, d, e, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL oor_latency: got ok=%b want 1", ok); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_data: got %h want 0", d); end
    drive(1'b1, 32'h1000, 32'h12345678, 4'hF);
    read_word(32'h0, d, e, ok);
    total++; if (!ok || d !== 32'hCAFEF00D || e !== 1'b0) begin bad++; $display("FAIL oor_write_kept: got ok=%b d=%h e=%b want ok=1 d=cafef00d e=0", ok, d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    for (int i = 0; i < 4; i++) begin
      exp[i] = 32'hA0000000 + 32'(i * 17);
      drive(1'b1, 32'(i * 4), exp[i], 4'hF);
    end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'(i * 4);
      step();
      if (i == 0) begin
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_early: got %b want 0", resp_valid); end
      end else begin
        total++; if (resp_valid !== 1'b1 || resp_data !== exp[i-1]) begin bad++; $display("FAIL b2b_resp%0d: got v=%b d=%h want v=1 d=%h", i-1, resp_valid, resp_data, exp[i-1]); end
      end
    end
    req_valid = 1'b0;
    step();
    total++; if (resp_valid !== 1'b1 || resp_data !== exp[3]) begin bad++; $display("FAIL b2b_resp3: got v=%b d=%h want v=1 d=%h", resp_valid, resp_data, exp[3]); end
    step();
    total++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin bad++; $display("FAIL b2b_tail: got v=%b d=%h want v=0 d=0", resp_valid, resp_data); end
  endtask

  task automatic test_reset_flush();
    int seen;
    int cyc;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h4;
    step();
    req_addr  = 32'h8;
    step();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 1'b0) seen++;
      step();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_resp: got %0d responses want 0", seen); end
    wait_ready(cyc);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back: got %b want 1", req_ready); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = 4'h0;
    test_reset();
`ifdef PIPELINED_RAM_INIT_CLEAR_EN
    test_init_clear();
`endif
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
